queue_access_arbiter: RTL and testbench

Single-port access controller for the 8-entry, 4-bit push/pop queue. It shares the queue's one-operation-per-cycle port between two producers (P0, P1) and one consumer (POP) using three-way round-robin arbitration. Requesters are gated by the queue's full and empty flags. A flush sequence drains the queue on command. It sits directly in front of the queue instance, and its q_* ports are the only path that drives the queue.

---
 rtl/queue_arb_pkg.sv | 21 ++
 rtl/queue_access_arbiter_rr3_picker.sv | 28 ++
 rtl/queue_access_arbiter.sv | 129 ++++++++++++
 tb/tb_queue_access_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_arb_pkg.sv
// Shared types and constants for the queue access arbiter.
// Holds the FSM state enum, requester indices and the ptr width.
package queue_arb_pkg;

    localparam int PTR_W = 2;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } arb_state_t;

    localparam logic [PTR_W-1:0] REQ_P0  = 2'd0;
    localparam logic [PTR_W-1:0] REQ_P1  = 2'd1;
    localparam logic [PTR_W-1:0] REQ_POP = 2'd2;

    // Advance a requester index modulo 3.
    function automatic logic [PTR_W-1:0] inc3(input logic [PTR_W-1:0] p);
        return (p >= REQ_POP) ? REQ_P0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/queue_access_arbiter_rr3_picker.sv
// Three-way round-robin picker, purely combinational.
// Ports: elig[2:0], ptr in; one-hot gnt[2:0], ptr_nxt out.
module rr3_picker
    import queue_arb_pkg::*;
(
    input  logic [2:0]       elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [2:0]       gnt,
    output logic [PTR_W-1:0] ptr_nxt
);

    logic [PTR_W-1:0] cand;

    // Walk ptr, ptr+1, ptr+2 (mod 3); the first eligible wins.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        cand    = (ptr > REQ_POP) ? REQ_P0 : ptr;
        for (int k = 0; k < 3; k++) begin
            if (gnt == 3'b000 && elig[cand]) begin
                gnt[cand] = 1'b1;
                ptr_nxt   = inc3(cand);
            end
            cand = inc3(cand);
        end
    end

endmodule

// File: rtl/queue_access_arbiter.sv
// Shares one push/pop queue port between two producers and a consumer.
// Ports: push_req/data, pop_req/data/valid, flush ctrl, q_* queue port.
module queue_access_arbiter
    import queue_arb_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        push_req,
    input  logic [DATA_W-1:0] push_data0,
    input  logic [DATA_W-1:0] push_data1,
    output logic [1:0]        push_gnt,
    input  logic              pop_req,
    output logic              pop_gnt,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    input  logic              flush,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [DATA_W-1:0] q_data_in,
    output logic              q_push_pop,
    output logic              q_enable,
    input  logic              q_full,
    input  logic              q_empty,
    input  logic [DATA_W-1:0] q_data_out
);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              flush_done_q, flush_done_d;

    logic [2:0]        elig;
    logic [2:0]        gnt;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              run;

    assign run = (state_q == ST_RUN);

    // Nothing is eligible outside RUN or while reset is held.
    always_comb begin
        elig = '0;
        if (reset && run) begin
            elig[REQ_P0]  = push_req[0] & ~q_full;
            elig[REQ_P1]  = push_req[1] & ~q_full;
            elig[REQ_POP] = pop_req & ~q_empty;
        end
    end

    rr3_picker u_picker (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    always_comb begin
        push_gnt   = {gnt[REQ_P1], gnt[REQ_P0]};
        pop_gnt    = gnt[REQ_POP];
        q_enable   = 1'b0;
        q_push_pop = 1'b0;
        q_data_in  = '0;
        if (run) begin
            q_enable   = |gnt;
            q_push_pop = gnt[REQ_P0] | gnt[REQ_P1];
            if (gnt[REQ_P0]) begin
                q_data_in = push_data0;
            end else if (gnt[REQ_P1]) begin
                q_data_in = push_data1;
            end
        end else begin
            // Drain: pop every cycle the queue still holds data.
            q_enable = reset & ~q_empty;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pop_data_d   = pop_data_q;
        pop_valid_d  = gnt[REQ_POP];
        flush_done_d = 1'b0;
        if (gnt[REQ_POP]) begin
            pop_data_d = q_data_out;
        end
        unique case (state_q)
            ST_RUN: begin
                if (|gnt) begin
                    ptr_d = ptr_nxt;
                end
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (q_empty) begin
                    state_d      = ST_RUN;
                    ptr_d        = REQ_P0;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            ptr_q        <= REQ_P0;
            pop_data_q   <= '0;
            pop_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pop_data_q   <= pop_data_d;
            pop_valid_q  <= pop_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign pop_data   = pop_data_q;
    assign pop_valid  = pop_valid_q;
    assign flush_busy = (state_q == ST_FLUSH);
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_queue_access_arbiter.sv
// Directed bench for queue_access_arbiter with an 8-entry queue model.
// Inputs change after negedge; outputs are sampled 1ns later.
module tb_queue_access_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] push_req = '0;
    logic [3:0] push_data0 = '0;
    logic [3:0] push_data1 = '0;
    logic [1:0] push_gnt;
    logic       pop_req = 1'b0;
    logic       pop_gnt;
    logic [3:0] pop_data;
    logic       pop_valid;
    logic       flush = 1'b0;
    logic       flush_busy;
    logic       flush_done;
    logic [3:0] q_data_in;
    logic       q_push_pop;
    logic       q_enable;
    logic       q_full;
    logic       q_empty;
    logic [3:0] q_data_out;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    queue_access_arbiter #(.DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_req   (push_req),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .push_gnt   (push_gnt),
        .pop_req    (pop_req),
        .pop_gnt    (pop_gnt),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .flush      (flush),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .q_data_in  (q_data_in),
        .q_push_pop (q_push_pop),
        .q_enable   (q_enable),
        .q_full     (q_full),
        .q_empty    (q_empty),
        .q_data_out (q_data_out)
    );

    // Behavioural 8-entry queue driven only by the DUT port.
    logic       model_clr = 1'b0;
    logic [3:0] mem [8];
    logic [2:0] rd_p, wr_p;
    int         cnt;
    logic       q_abuse;

    assign q_full     = (cnt == 8);
    assign q_empty    = (cnt == 0);
    assign q_data_out = mem[rd_p];

    always @(posedge clk) begin
        if (model_clr) begin
            cnt     <= 0;
            rd_p    <= '0;
            wr_p    <= '0;
            q_abuse <= 1'b0;
        end else if (q_enable) begin
            if (q_push_pop) begin
                if (cnt == 8) q_abuse <= 1'b1;
                mem[wr_p] <= q_data_in;
                wr_p      <= wr_p + 3'd1;
                cnt       <= cnt + 1;
            end else begin
                if (cnt == 0) q_abuse <= 1'b1;
                rd_p <= rd_p + 3'd1;
                cnt  <= cnt - 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; model_clr = 1'b1;
        push_req = '0; pop_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b1; model_clr = 1'b0;
    endtask

    // Leaves push_req active; the caller's next step overrides it.
    task automatic fill_p0(input int n, input logic [3:0] base);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            push_req = 2'b01; pop_req = 1'b0;
            push_data0 = base + 4'(i);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; model_clr = 1'b1;
        push_req = 2'b11; pop_req = 1'b1;
        push_data0 = 4'h3; push_data1 = 4'h5;
        @(negedge clk);
        #1;
        vecs++;
        if ({push_gnt, pop_gnt, q_enable} !== 4'b0) begin
            errs++;
            $display("FAIL rst_gnt got %b req 0000",
                     {push_gnt, pop_gnt, q_enable});
        end
        vecs++;
        if ({pop_valid, pop_data, flush_busy, flush_done} !== 7'b0) begin
            errs++;
            $display("FAIL rst_regs got %b req 0",
                     {pop_valid, pop_data, flush_busy, flush_done});
        end
        reset = 1'b1; model_clr = 1'b0;
        #1;
        vecs++;
        if ({push_gnt, q_push_pop, q_data_in} !== 7'b01_1_0011) begin
            errs++;
            $display("FAIL rst_first got %b req 0110011",
                     {push_gnt, q_push_pop, q_data_in});
        end
        @(negedge clk); #1;
        vecs++;
        if ({push_gnt, q_data_in} !== 6'b10_0101) begin
            errs++;
            $display("FAIL rst_second got %b req 100101",
                     {push_gnt, q_data_in});
        end
        @(negedge clk); #1;
        vecs++;
        if ({push_gnt, pop_gnt, q_enable, q_push_pop} !== 5'b00_1_1_0) begin
            errs++;
            $display("FAIL rst_third got %b req 00110",
                     {push_gnt, pop_gnt, q_enable, q_push_pop});
        end
        @(negedge clk);
        push_req = '0; pop_req = 1'b0;
        #1;
        vecs++;
        if ({pop_valid, pop_data} !== 5'b1_0011) begin
            errs++;
            $display("FAIL rst_popdata got %b req 10011",
                     {pop_valid, pop_data});
        end
    endtask

    task automatic test_fill_alternate();
        logic [1:0] eg;
        logic [3:0] ed;
        do_reset();
        push_data0 = 4'h1; push_data1 = 4'h2;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            push_req = 2'b11; pop_req = 1'b0;
            #1;
            eg = (i == 8) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            ed = (i == 8) ? 4'h0 : ((i % 2 == 0) ? 4'h1 : 4'h2);
            vecs++;
            if (push_gnt !== eg || q_data_in !== ed ||
                q_enable !== (i != 8) || q_push_pop !== (i != 8)) begin
                errs++;
                $display("FAIL fill[%0d] gnt %b data %h en %b; req %b %h %b",
                         i, push_gnt, q_data_in, q_enable, eg, ed, i != 8);
            end
        end
    endtask

    task automatic test_drain();
        logic [3:0] ed;
        do_reset();
        fill_p0(8, 4'hA);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            push_req = '0; pop_req = 1'b1;
            #1;
            vecs++;
            if (pop_gnt !== (i < 8) || q_enable !== (i < 8) ||
                q_push_pop !== 1'b0) begin
                errs++;
                $display("FAIL drain_gnt[%0d] gnt %b en %b pp %b req %b",
                         i, pop_gnt, q_enable, q_push_pop, i < 8);
            end
            vecs++;
            if (pop_valid !== (i >= 1 && i <= 8)) begin
                errs++;
                $display("FAIL drain_valid[%0d] got %b", i, pop_valid);
            end
            if (i >= 1 && i <= 8) begin
                ed = 4'hA + 4'(i - 1);
                vecs++;
                if (pop_data !== ed) begin
                    errs++;
                    $display("FAIL drain_data[%0d] got %h req %h",
                             i, pop_data, ed);
                end
            end
        end
        pop_req = 1'b0;
    endtask

    task automatic test_three_way();
        int  n [3];
        int  exp_idx;
        logic [2:0] got;
        n = '{0, 0, 0};
        do_reset();
        fill_p0(3, 4'h4);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            push_req = 2'b11; pop_req = 1'b1;
            #1;
            got = {pop_gnt, push_gnt};
            exp_idx = (1 + k) % 3;
            vecs++;
            if (got !== 3'(1 << exp_idx) || q_enable !== 1'b1) begin
                errs++;
                $display("FAIL rr[%0d] gnt %b req %b", k, got,
                         3'(1 << exp_idx));
            end
            for (int j = 0; j < 3; j++) if (got[j]) n[j]++;
        end
        push_req = '0; pop_req = 1'b0;
        vecs++;
        if (n[0] !== 4 || n[1] !== 4 || n[2] !== 4) begin
            errs++;
            $display("FAIL rr_share got %0d/%0d/%0d req 4/4/4",
                     n[0], n[1], n[2]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill_p0(5, 4'h1);
        @(negedge clk);
        push_req = 2'b11; pop_req = 1'b0; flush = 1'b1;
        push_data0 = 4'h7; push_data1 = 4'h9;
        #1;
        vecs++;
        if (push_gnt !== 2'b10 || q_enable !== 1'b1 || flush_busy !== 1'b0) begin
            errs++;
            $display("FAIL flush_entry gnt %b en %b busy %b req 10 1 0",
                     push_gnt, q_enable, flush_busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            flush = (i == 1);
            #1;
            vecs++;
            if (i < 7 &&
                ({push_gnt, pop_gnt, pop_valid, flush_busy, flush_done,
                  q_enable, q_push_pop} !== {4'b0000, 1'b1, 1'b0,
                  (i < 6), 1'b0})) begin
                errs++;
                $display("FAIL flush[%0d] g%b p%b v%b b%b d%b en%b pp%b",
                         i, push_gnt, pop_gnt, pop_valid, flush_busy,
                         flush_done, q_enable, q_push_pop);
            end
            if (i == 7 && (flush_done !== 1'b1 || flush_busy !== 1'b0 ||
                           push_gnt !== 2'b01 || q_data_in !== 4'h7)) begin
                errs++;
                $display("FAIL flush_done d%b b%b g%b din %h req 1 0 01 7",
                         flush_done, flush_busy, push_gnt, q_data_in);
            end
        end
        @(negedge clk);
        push_req = '0;
        #1;
        vecs++;
        if (flush_done !== 1'b0) begin
            errs++;
            $display("FAIL flush_done_pulse got %b req 0", flush_done);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        fill_p0(5, 4'h2);
        @(negedge clk);
        push_req = '0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++;
        if (q_enable !== 1'b0) begin
            errs++;
            $display("FAIL frst_en got %b req 0", q_enable);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if ({flush_busy, flush_done, pop_valid, q_enable} !== 4'b0) begin
                errs++;
                $display("FAIL frst[%0d] b%b d%b v%b en%b req 0000", i,
                         flush_busy, flush_done, pop_valid, q_enable);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_empty_flush();
        do_reset();
        @(negedge clk);
        flush = 1'b1;
        #1;
        vecs++;
        if (q_enable !== 1'b0) begin
            errs++;
            $display("FAIL eflush_en0 got %b req 0", q_enable);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        vecs++;
        if ({flush_busy, q_enable, flush_done} !== 3'b100) begin
            errs++;
            $display("FAIL eflush_busy got %b req 100",
                     {flush_busy, q_enable, flush_done});
        end
        @(negedge clk); #1;
        vecs++;
        if ({flush_busy, flush_done} !== 2'b01) begin
            errs++;
            $display("FAIL eflush_done got %b req 01",
                     {flush_busy, flush_done});
        end
        @(negedge clk); #1;
        vecs++;
        if (flush_done !== 1'b0) begin
            errs++;
            $display("FAIL eflush_pulse got %b req 0", flush_done);
        end
    endtask

    task automatic test_queue_abuse();
        vecs++;
        if (q_abuse !== 1'b0) begin
            errs++;
            $display("FAIL queue_abuse got %b req 0", q_abuse);
        end
    endtask

    initial begin
        test_reset();
        test_queue_abuse();
        test_fill_alternate();
        test_queue_abuse();
        test_drain();
        test_queue_abuse();
        test_three_way();
        test_queue_abuse();
        test_flush();
        test_queue_abuse();
        test_flush_reset();
        test_empty_flush();
        test_queue_abuse();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
